// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 lines, frames and checks
// bytes, folds E0/F0 prefixes into 10-bit events and queues them in a FWFT FIFO.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FIFO_AW        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FW-1:0]      FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]      TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [1:0]         clk_sync, data_sync;
  logic               clk_s, data_s;
  logic               fclk, fall;
  logic [FW-1:0]      filt_cnt;
  state_t             state, next_state;
  logic [9:0]         shreg;
  logic [3:0]         bit_cnt;
  logic [TW-1:0]      to_cnt;
  logic               ext, brk;
  logic               timeout_hit, frame_good, push_req, push_ok, pop, full;
  logic [7:0]         code;
  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // fclk follows clk_s only after FILTER_LEN consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      fclk     <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == fclk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_MAX) begin
      fclk     <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign fall = fclk && !clk_s && (filt_cnt == FILT_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    next_state = state;
    unique case (state)
      IDLE:    if (fall && !data_s) next_state = RECV;
      RECV: begin
        if (timeout_hit)                     next_state = IDLE;
        else if (fall && bit_cnt == 4'd9)    next_state = CHECK;
      end
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign code = shreg[7:0];

  always_comb begin
    timeout_hit = (state == RECV) && !fall && (to_cnt == TO_MAX);
    frame_good  = (state == CHECK) && shreg[9] && (^shreg[8:0]);
    frame_err   = ((state == IDLE) && fall && data_s) || timeout_hit ||
                  ((state == CHECK) && !frame_good);
    push_req    = frame_good && (code != 8'hE0) && (code != 8'hF0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
      ext     <= 1'b0;
      brk     <= 1'b0;
    end else begin
      to_cnt <= (state == RECV && !fall) ? to_cnt + 1'b1 : '0;
      if (state == IDLE && fall && !data_s) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (state == RECV && fall) begin
        shreg   <= {data_s, shreg[9:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      // Flags survive a timeout but not a bad frame or a completed event.
      if (state == CHECK) begin
        if (!frame_good) begin
          ext <= 1'b0;
          brk <= 1'b0;
        end else if (code == 8'hE0) begin
          ext <= 1'b1;
        end else if (code == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

  assign full     = (count == FULL_CNT);
  assign valid    = (count != '0);
  assign pop      = valid && ready;
  assign push_ok  = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;
  assign data     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {brk, ext, code};
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames and checks the popped event stream.
module tb_ps2_scancode_rx;

  localparam int TO_CYC = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] data;
  logic       valid, frame_err, overflow;
  logic       ready = 1'b0;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int vld_cnt = 0;
  int got_base = 0;
  int err0, ovf0, vld0;
  logic [9:0] got [$];
  logic [9:0] exp_q [$];

  ps2_scancode_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO_CYC), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid && ready) got.push_back(data);
      if (frame_err) err_cnt++;
      if (overflow)  ovf_cnt++;
      if (valid)     vld_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    if (obs !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input bit pop_at_check);
    ps2_data = v;
    tick(5);
    ps2_clk = 1'b0;
    if (pop_at_check) begin
      // Stop-bit sample lands 6 cycles after the raw fall; CHECK is the cycle after.
      tick(6);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(3);
    end else begin
      tick(10);
    end
    ps2_clk = 1'b1;
    tick(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_par, input bit pop_at_check);
    logic [10:0] f;
    f = {1'b1, good_par ? ~(^b) : (^b), b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], pop_at_check && (i == 10));
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_n"}, 32'(got.size() - got_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_base + i < got.size()) check(tag, 32'(got[got_base + i]), 32'(exp_q[i]));
      else                           check(tag, 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    exp_q.delete();
    got_base = got.size();
  endtask

  initial begin
    logic [10:0] part;

    tick(3);
    check("rst_valid", 32'(valid), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    tick(10);

    // Plain make code
    ready = 1'b1;
    err0 = err_cnt; vld0 = vld_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    exp_q.push_back(10'h01C);
    compare_events("make_1c");
    check("make_vld_cycles", 32'(vld_cnt - vld0), 1);
    check("make_err", 32'(err_cnt - err0), 0);

    // Extended break, then plain make proves flags cleared
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h14, 1'b1, 1'b0);
    exp_q.push_back(10'h314);
    compare_events("ext_brk_14");
    send_frame(8'h12, 1'b1, 1'b0);
    exp_q.push_back(10'h012);
    compare_events("after_12");

    // Parity errors
    err0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("par_err", 32'(err_cnt - err0), 1);
    compare_events("par_nopush");
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    check("par_err2", 32'(err_cnt - err0), 2);
    exp_q.push_back(10'h01C);
    compare_events("brk_cleared");

    // Timeout after 5 bits
    err0 = err_cnt;
    part = {1'b1, ~(^8'h55), 8'h55, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(part[i], 1'b0);
    ps2_data = 1'b1;
    tick(TO_CYC + 20);
    check("timeout_err", 32'(err_cnt - err0), 1);
    send_frame(8'h29, 1'b1, 1'b0);
    check("timeout_err_after", 32'(err_cnt - err0), 1);
    exp_q.push_back(10'h029);
    compare_events("after_timeout");

    // Overflow on the 9th event
    ready = 1'b0;
    ovf0 = ovf_cnt;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("ovf_before", 32'(ovf_cnt - ovf0), 0);
    send_frame(8'h09, 1'b1, 1'b0);
    check("ovf_9th", 32'(ovf_cnt - ovf0), 1);
    check("ovf_valid", 32'(valid), 1);
    ready = 1'b1;
    tick(20);
    for (int i = 1; i <= 8; i++) exp_q.push_back(10'(i));
    compare_events("ovf_drain");
    check("ovf_empty", 32'(valid), 0);

    // Push into a full FIFO with a same-cycle pop
    ready = 1'b0;
    ovf0 = ovf_cnt;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0);
    send_frame(8'h0A, 1'b1, 1'b1);
    check("full_pushpop_ovf", 32'(ovf_cnt - ovf0), 0);
    ready = 1'b1;
    tick(20);
    for (int i = 1; i <= 8; i++) exp_q.push_back(10'(i));
    exp_q.push_back(10'h00A);
    compare_events("full_pushpop");

    // Short glitch on the idle clock line
    err0 = err_cnt;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(20);
    check("glitch_err", 32'(err_cnt - err0), 0);
    compare_events("glitch_none");

    // Reset mid-frame discards the partial frame
    part = {1'b1, ~(^8'h33), 8'h33, 1'b0};
    for (int i = 0; i < 4; i++) send_bit(part[i], 1'b0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    ps2_data = 1'b1;
    tick(5);
    send_frame(8'h1C, 1'b1, 1'b0);
    check("rst_mid_err", 32'(err_cnt - err0), 0);
    exp_q.push_back(10'h01C);
    compare_events("rst_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Parametrised PS/2 keyboard receiver that turns the raw `ps2_clk`/`ps2_data` lines into buffered scan-code events. It filters glitches on the PS/2 clock, checks start, parity and stop bits, and aborts stalled frames on a timeout. E0/F0 prefixes are folded into one 10-bit event word (break, extended, code), and events queue in a first-word-fall-through FIFO drained by a valid/ready handshake. It sits between the PS/2 pins and the keymap/modifier logic, replacing unbuffered single-byte capture.

## Interface
- `FILTER_LEN`, 4: consecutive cycles synced `ps2_clk` must hold a new level before the filtered clock changes (≥1).
- `TIMEOUT_CYCLES`, 25000: max cycles between falling edges inside a frame before abort (≥2).
- `FIFO_AW`, 3: FIFO depth = 2^FIFO_AW events.
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `data` out 10: FIFO head; [9] break, [8] extended, [7:0] scan code.
- `valid` out 1: FIFO not empty.
- `ready` in 1: consumer accepts head when `valid && ready`.
- `frame_err` out 1: one-cycle pulse on start/parity/stop error or timeout.
- `overflow` out 1: one-cycle pulse when a completed event is dropped because the FIFO is full.

## Operation
- Synchroniser: two flops per PS/2 line, reset to 1 (bus idle high).
- Filter: counter of width clog2(FILTER_LEN+1). `fclk` (reset 1) takes the synced level only after it differs from `fclk` for FILTER_LEN consecutive cycles; any return resets the counter.
- Bits are sampled from synced `ps2_data` on the cycle `fclk` falls.
- FSM states IDLE, RECV, CHECK (reset IDLE):
  - IDLE: on a falling edge with data=0 (start bit), clear the shift register and bit count, then go to RECV. On a falling edge with data=1, pulse `frame_err` and stay in IDLE.
  - RECV: each falling edge shifts data in LSB first. Bit count 0..7 is data, 8 is parity, 9 is stop. After the stop edge, go to CHECK. The timeout counter clears on every falling edge. If it reaches TIMEOUT_CYCLES, pulse `frame_err`, go to IDLE, and keep the prefix flags.
  - CHECK (one cycle, then IDLE): a frame is good if stop=1 and the XOR of the 8 data bits and parity is 1 (odd parity). A bad frame pulses `frame_err`, clears `ext` and `brk`, and is dropped.
- Prefix handling on a good byte:
  - E0: set `ext`.
  - F0: set `brk`.
  - Any other byte: push {brk, ext, byte}, then clear both flags. The flags clear even if the push is dropped.
- FIFO: 2^FIFO_AW × 10 bits. Read/write pointers are FIFO_AW bits and wrap naturally; the occupancy count is FIFO_AW+1 bits.
  - Push is accepted if not full, or if full and a pop happens the same cycle.
  - Otherwise the push is dropped and `overflow` pulses.
  - Pop on `valid && ready`. Simultaneous push and pop leaves the count unchanged.
  - `data` is the head entry. It is stable while `valid && !ready`. It is don't-care when `valid=0`; the bench must not check it.

## Timing
- Reset values: `valid`=0, `frame_err`=0, `overflow`=0, FIFO empty, `ext`=`brk`=0, FSM IDLE, `fclk`=1. Reset mid-frame discards the partial frame.
- Raw `ps2_clk` fall to sampling cycle: 2 (sync) + FILTER_LEN cycles.
- Stop-bit sample at cycle N: CHECK at N+1, FIFO write at the end of N+1, `valid`=1 and `data` visible at N+2.
- `frame_err` asserts in the CHECK cycle (N+1) for a bad frame, or in the timeout cycle.
- `overflow` asserts in the CHECK cycle (N+1).
- Pop at cycle M: the next entry is on `data` at M+1. `valid` falls at M+1 if the FIFO becomes empty.
- Throughput: a new frame can start the cycle after CHECK.

## Test plan
- FILTER_LEN=4. Frame 0x1C, good parity, `ready`=1 → one `valid` cycle with `data`=0x01C, no errors.
- Bytes E0, F0, 14 → exactly one event, `data`=0x314. Then byte 12 → `data`=0x012, showing the flags cleared.
- Byte 0x1C with even parity → `frame_err` pulse, no push. Then F0 with good parity, 1C with bad parity, then 1C good → single event 0x01C; the F0 flag is cleared by the bad frame.
- Stall after 5 bits for TIMEOUT_CYCLES → `frame_err` exactly once, FSM back in IDLE. A following good frame 0x29 → `data`=0x029.
- `ready`=0; send 9 make codes 0x01..0x09 with FIFO_AW=3 → `overflow` on the 9th. Then `ready`=1 → reads 0x001..0x008 in order, then `valid`=0. Separately, with the FIFO full, push and pop in the same cycle → push accepted, no `overflow`, count stays 8.
- 3-cycle low glitch on `ps2_clk` while idle → no `fclk` change, no `frame_err`. Assert `reset` mid-frame, then send a good 0x1C → only 0x01C is produced.
